time_keeper: RTL and testbench
==============================

Name: time_keeper

Overview:
- Downstream consumer of the clock divisor's tick outputs. Keeps time of day as BCD hours, minutes and seconds (24-hour format).
- Has a two-button set mode and produces blink masks for the field being edited, which the 7-segment display driver consumes.
- pulse_1hz advances time; pulse_500ms drives the blink phase.

Parameters:
- RESET_HOUR, 0, hour loaded on reset (0..23).
- RESET_MIN, 0, minute loaded on reset (0..59).

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  synchronous, active-high reset.
- pulse_1hz  in  1  one-cycle tick, once per second, from the divisor.
- pulse_500ms  in  1  one-cycle tick, every 500 ms, from the divisor (also high on the cycle pulse_1hz is high).
- btn_mode  in  1  debounced one-cycle press pulse; cycles the mode.
- btn_inc  in  1  debounced one-cycle press pulse; increments the selected field.
- hour_tens  out  2  BCD 0..2.
- hour_ones  out  4  BCD 0..9.
- min_tens  out  3  BCD 0..5.
- min_ones  out  4  BCD 0..9.
- sec_tens  out  3  BCD 0..5.
- sec_ones  out  4  BCD 0..9.
- mode  out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN.
- hour_blank  out  1  high = display blanks the hour digits.
- min_blank  out  1  high = display blanks the minute digits.
- day_wrap  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover.

Behaviour:
- Single clock domain; all state updates on posedge clk; all outputs registered.
- rst is synchronous, active-high, and has priority over every other input.
- Reset values:
  - Time = RESET_HOUR:RESET_MIN:00.
  - mode = RUN.
  - blink_phase = 0.
  - hour_blank = 0, min_blank = 0, day_wrap = 0.
- Digit storage:
  - Each field is kept as BCD tens/ones; no binary-to-BCD conversion.
  - Ones wraps 9 -> 0 and carries into tens.
  - Field limits: seconds 59, minutes 59, hours 23 (ones wraps 3 -> 0 when tens = 2).
- State machine: RUN -> SET_HOUR -> SET_MIN -> RUN, advanced on btn_mode. Unused encoding 11 returns to RUN on the next cycle.
- RUN:
  - pulse_1hz increments seconds; outputs change one cycle after the tick.
  - 59 s -> 00 carries +1 minute in the same cycle.
  - 59 min -> 00 carries +1 hour.
  - 23:59:59 -> 00:00:00 asserts day_wrap for exactly one cycle, aligned with the 00:00:00 outputs.
  - btn_inc is ignored.
- Entering SET_HOUR from RUN: seconds cleared to 00 in the same update.
- SET_HOUR and SET_MIN:
  - pulse_1hz is ignored; time is frozen.
  - btn_inc in SET_HOUR: hours +1, wraps 23 -> 00, no carry, minutes untouched.
  - btn_inc in SET_MIN: minutes +1, wraps 59 -> 00, no carry into hours.
- Leaving SET_MIN -> RUN: time resumes counting from HH:MM:00 on the next pulse_1hz.
- Simultaneous events:
  - btn_mode and btn_inc in the same cycle: the mode change wins and btn_inc is dropped.
  - btn_mode and pulse_1hz in the same RUN cycle: the tick is dropped and the seconds clear applies.
- Blink:
  - blink_phase toggles on every pulse_500ms.
  - blink_phase is forced to 0 on any mode change, so a newly selected field shows immediately.
  - hour_blank = (mode == SET_HOUR) and blink_phase.
  - min_blank = (mode == SET_MIN) and blink_phase.
  - btn_inc also forces blink_phase to 0, so the incremented value is visible.
  - Both blank outputs are 0 in RUN.
- Reset asserted mid-operation (in any mode) restores reset values on the next edge; no partial carries.

Test Plan:
- Reset with RESET_HOUR=12, RESET_MIN=34, then release -> outputs 12:34:00, mode=00, blanks=0, day_wrap=0.
- Preload 23:59:58, two pulse_1hz ticks -> 23:59:59, then 00:00:00 with day_wrap high exactly one cycle.
- Preload 09:59:59, one tick -> 10:00:00 (hour_ones 9 -> 0 carries into hour_tens 0 -> 1); no day_wrap.
- From 10:20:45:
  - btn_mode -> SET_HOUR with seconds = 00.
  - 15 btn_inc -> hour 01.
  - btn_mode -> SET_MIN.
  - 45 btn_inc -> minute 05.
  - Repeated pulse_1hz during edit leaves time frozen.
  - btn_mode -> RUN; next tick -> 01:05:01.
- In SET_HOUR, drive pulse_500ms four times -> hour_blank toggles 1, 0, 1, 0; min_blank stays 0.
  - btn_inc while blanked clears hour_blank the next cycle.
- Edge cases:
  - btn_mode and btn_inc in the same cycle in SET_HOUR -> mode = SET_MIN, hour unchanged.
  - rst asserted in SET_MIN -> RUN with reset time on the next edge.

Source files
------------

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - BCD 24-hour time of day with two-button set mode and blink masks.
// Every field is kept directly as BCD tens/ones digits, so no binary-to-BCD conversion is needed.
module time_keeper #(
  parameter int RESET_HOUR = 0,
  parameter int RESET_MIN  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse_1hz,
  input  logic       pulse_500ms,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [1:0] hour_tens,
  output logic [3:0] hour_ones,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] mode,
  output logic       hour_blank,
  output logic       min_blank,
  output logic       day_wrap
);

  localparam logic [1:0] RUN      = 2'b00;
  localparam logic [1:0] SET_HOUR = 2'b01;
  localparam logic [1:0] SET_MIN  = 2'b10;

  localparam logic [1:0] RST_HT = 2'(RESET_HOUR / 10);
  localparam logic [3:0] RST_HO = 4'(RESET_HOUR % 10);
  localparam logic [2:0] RST_MT = 3'(RESET_MIN / 10);
  localparam logic [3:0] RST_MO = 4'(RESET_MIN % 10);

  logic [1:0] hour_tens_q, hour_tens_d;
  logic [3:0] hour_ones_q, hour_ones_d;
  logic [2:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [2:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic [1:0] mode_q, mode_d;
  logic       blink_q, blink_d;
  logic       day_wrap_q, day_wrap_d;
  logic       hour_blank_q, min_blank_q;

  logic sec_max, min_max, hour_max;

  // Modulo-60 BCD increment: {tens, ones}; wraps 59 -> 00.
  function automatic logic [6:0] inc_sixty(input logic [2:0] tens, input logic [3:0] ones);
    if (ones != 4'd9)      return {tens, ones + 4'd1};
    else if (tens != 3'd5) return {tens + 3'd1, 4'd0};
    else                   return 7'd0;
  endfunction

  // Modulo-24 BCD increment: {tens, ones}; wraps 23 -> 00.
  function automatic logic [5:0] inc_hour(input logic [1:0] tens, input logic [3:0] ones);
    if (tens == 2'd2 && ones == 4'd3) return 6'd0;
    else if (ones == 4'd9)            return {tens + 2'd1, 4'd0};
    else                              return {tens, ones + 4'd1};
  endfunction

  assign sec_max  = (sec_tens_q == 3'd5) && (sec_ones_q == 4'd9);
  assign min_max  = (min_tens_q == 3'd5) && (min_ones_q == 4'd9);
  assign hour_max = (hour_tens_q == 2'd2) && (hour_ones_q == 4'd3);

  always_comb begin
    hour_tens_d = hour_tens_q;
    hour_ones_d = hour_ones_q;
    min_tens_d  = min_tens_q;
    min_ones_d  = min_ones_q;
    sec_tens_d  = sec_tens_q;
    sec_ones_d  = sec_ones_q;
    mode_d      = mode_q;
    blink_d     = blink_q;
    day_wrap_d  = 1'b0;

    if (btn_mode) begin
      // Mode change beats both a coincident tick and a coincident increment.
      blink_d = 1'b0;
      case (mode_q)
        RUN: begin
          mode_d     = SET_HOUR;
          sec_tens_d = 3'd0;
          sec_ones_d = 4'd0;
        end
        SET_HOUR: mode_d = SET_MIN;
        default:  mode_d = RUN;
      endcase
    end else begin
      case (mode_q)
        RUN: begin
          if (pulse_500ms) blink_d = ~blink_q;
          if (pulse_1hz) begin
            {sec_tens_d, sec_ones_d} = inc_sixty(sec_tens_q, sec_ones_q);
            if (sec_max) begin
              {min_tens_d, min_ones_d} = inc_sixty(min_tens_q, min_ones_q);
              if (min_max) begin
                {hour_tens_d, hour_ones_d} = inc_hour(hour_tens_q, hour_ones_q);
                day_wrap_d = hour_max;
              end
            end
          end
        end
        SET_HOUR, SET_MIN: begin
          if (btn_inc) begin
            blink_d = 1'b0;
            if (mode_q == SET_HOUR)
              {hour_tens_d, hour_ones_d} = inc_hour(hour_tens_q, hour_ones_q);
            else
              {min_tens_d, min_ones_d} = inc_sixty(min_tens_q, min_ones_q);
          end else if (pulse_500ms) begin
            blink_d = ~blink_q;
          end
        end
        default: begin
          mode_d  = RUN;
          blink_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hour_tens_q  <= RST_HT;
      hour_ones_q  <= RST_HO;
      min_tens_q   <= RST_MT;
      min_ones_q   <= RST_MO;
      sec_tens_q   <= 3'd0;
      sec_ones_q   <= 4'd0;
      mode_q       <= RUN;
      blink_q      <= 1'b0;
      day_wrap_q   <= 1'b0;
      hour_blank_q <= 1'b0;
      min_blank_q  <= 1'b0;
    end else begin
      hour_tens_q  <= hour_tens_d;
      hour_ones_q  <= hour_ones_d;
      min_tens_q   <= min_tens_d;
      min_ones_q   <= min_ones_d;
      sec_tens_q   <= sec_tens_d;
      sec_ones_q   <= sec_ones_d;
      mode_q       <= mode_d;
      blink_q      <= blink_d;
      day_wrap_q   <= day_wrap_d;
      hour_blank_q <= (mode_d == SET_HOUR) && blink_d;
      min_blank_q  <= (mode_d == SET_MIN) && blink_d;
    end
  end

  assign hour_tens  = hour_tens_q;
  assign hour_ones  = hour_ones_q;
  assign min_tens   = min_tens_q;
  assign min_ones   = min_ones_q;
  assign sec_tens   = sec_tens_q;
  assign sec_ones   = sec_ones_q;
  assign mode       = mode_q;
  assign hour_blank = hour_blank_q;
  assign min_blank  = min_blank_q;
  assign day_wrap   = day_wrap_q;

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - randomized and directed bench for time_keeper against a seconds-of-day model.
module tb_time_keeper;

  logic       clk = 1'b0;
  logic       rst, pulse_1hz, pulse_500ms, btn_mode, btn_inc;
  logic [1:0] hour_tens;
  logic [3:0] hour_ones;
  logic [2:0] min_tens;
  logic [3:0] min_ones;
  logic [2:0] sec_tens;
  logic [3:0] sec_ones;
  logic [1:0] mode;
  logic       hour_blank, min_blank, day_wrap;

  always #5 clk = ~clk;

  time_keeper #(.RESET_HOUR(12), .RESET_MIN(34)) dut (
    .clk(clk), .rst(rst), .pulse_1hz(pulse_1hz), .pulse_500ms(pulse_500ms),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hour_tens(hour_tens), .hour_ones(hour_ones), .min_tens(min_tens),
    .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .mode(mode), .hour_blank(hour_blank), .min_blank(min_blank), .day_wrap(day_wrap)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: time as whole seconds of the day, mode as 0/1/2.
  int m_tod, m_mode;
  bit m_ph, m_dw;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [23:0] cur_time();
    return {2'b0, hour_tens, hour_ones, 1'b0, min_tens, min_ones, 1'b0, sec_tens, sec_ones};
  endfunction

  function automatic logic [23:0] model_time();
    return {bcd(m_tod / 3600), bcd((m_tod / 60) % 60), bcd(m_tod % 60)};
  endfunction

  task automatic model_step(input bit r, input bit p1, input bit p5, input bit bm, input bit bi);
    int h, m;
    h = m_tod / 3600;
    m = (m_tod / 60) % 60;
    m_dw = 1'b0;
    if (r) begin
      m_tod = 12 * 3600 + 34 * 60;
      m_mode = 0;
      m_ph = 1'b0;
    end else if (bm) begin
      m_ph = 1'b0;
      if (m_mode == 0) begin
        m_tod = m_tod - (m_tod % 60);
        m_mode = 1;
      end else begin
        m_mode = (m_mode == 1) ? 2 : 0;
      end
    end else if (m_mode == 0) begin
      if (p5) m_ph = ~m_ph;
      if (p1) begin
        m_tod = m_tod + 1;
        if (m_tod == 86400) begin
          m_tod = 0;
          m_dw = 1'b1;
        end
      end
    end else if (bi) begin
      m_ph = 1'b0;
      if (m_mode == 1) m_tod = ((h + 1) % 24) * 3600 + m * 60 + (m_tod % 60);
      else             m_tod = h * 3600 + ((m + 1) % 60) * 60 + (m_tod % 60);
    end else if (p5) begin
      m_ph = ~m_ph;
    end
  endtask

  task automatic check_all();
    check_eq("time", 32'(cur_time()), 32'(model_time()));
    check_eq("mode", 32'(mode), 32'(m_mode));
    check_eq("hour_blank", 32'(hour_blank), 32'(m_mode == 1 && m_ph));
    check_eq("min_blank", 32'(min_blank), 32'(m_mode == 2 && m_ph));
    check_eq("day_wrap", 32'(day_wrap), 32'(m_dw));
  endtask

  task automatic step(input bit r, input bit p1, input bit p5, input bit bm, input bit bi);
    rst = r; pulse_1hz = p1; pulse_500ms = p5; btn_mode = bm; btn_inc = bi;
    @(posedge clk);
    model_step(r, p1, p5, bm, bi);
    #1;
    check_all();
    rst = 1'b0; pulse_1hz = 1'b0; pulse_500ms = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
  endtask

  task automatic tick();       step(0, 1, 1, 0, 0); endtask
  task automatic press_mode(); step(0, 0, 0, 1, 0); endtask
  task automatic press_inc();  step(0, 0, 0, 0, 1); endtask

  initial begin
    rst = 1'b1; pulse_1hz = 1'b0; pulse_500ms = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    m_tod = 0; m_mode = 0; m_ph = 1'b0; m_dw = 1'b0;
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0);
    check_eq("reset_time", 32'(cur_time()), 32'h123400);
    check_eq("reset_mode", 32'(mode), 32'd0);

    // Bring the clock to 23:59:58 and across midnight.
    press_mode();
    repeat (11) press_inc();
    press_mode();
    repeat (25) press_inc();
    press_mode();
    repeat (58) tick();
    check_eq("pre_wrap", 32'(cur_time()), 32'h235958);
    tick();
    check_eq("last_second", 32'(cur_time()), 32'h235959);
    tick();
    check_eq("wrap_time", 32'(cur_time()), 32'h000000);
    check_eq("wrap_pulse", 32'(day_wrap), 32'd1);
    step(0, 0, 0, 0, 0);
    check_eq("wrap_one_cycle", 32'(day_wrap), 32'd0);

    // 09:59:59 -> 10:00:00 hour tens carry.
    press_mode();
    repeat (9) press_inc();
    press_mode();
    repeat (59) press_inc();
    press_mode();
    repeat (59) tick();
    tick();
    check_eq("hour_carry", 32'(cur_time()), 32'h100000);
    check_eq("hour_carry_nowrap", 32'(day_wrap), 32'd0);

    // Reach 10:20:45, then edit to 01:05.
    press_mode();
    press_mode();
    repeat (20) press_inc();
    press_mode();
    repeat (45) tick();
    check_eq("edit_start", 32'(cur_time()), 32'h102045);
    press_mode();
    check_eq("enter_set_hour", 32'(cur_time()), 32'h102000);
    check_eq("enter_set_hour_mode", 32'(mode), 32'd1);
    repeat (15) press_inc();
    check_eq("hour_wrap_edit", 32'(cur_time()), 32'h012000);
    press_mode();
    repeat (45) press_inc();
    check_eq("min_wrap_edit", 32'(cur_time()), 32'h010500);
    repeat (5) tick();
    check_eq("frozen", 32'(cur_time()), 32'h010500);
    press_mode();
    tick();
    check_eq("resume", 32'(cur_time()), 32'h010501);

    // Blink in SET_HOUR.
    press_mode();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 0);
      check_eq("blink_hour", 32'(hour_blank), 32'((i % 2) == 0));
      check_eq("blink_min", 32'(min_blank), 32'd0);
    end
    step(0, 0, 1, 0, 0);
    press_inc();
    check_eq("inc_unblank", 32'(hour_blank), 32'd0);

    // Mode beats increment; reset from SET_MIN.
    step(0, 0, 0, 1, 1);
    check_eq("mode_beats_inc_mode", 32'(mode), 32'd2);
    check_eq("mode_beats_inc_time", 32'(cur_time()), 32'h020500);
    step(1, 0, 0, 0, 0);
    check_eq("rst_in_set_min", 32'(cur_time()), 32'h123400);
    check_eq("rst_in_set_min_mode", 32'(mode), 32'd0);

    // Randomized traffic; pulse_1hz always coincides with pulse_500ms.
    for (int i = 0; i < 20000; i++) begin
      bit p5, p1, bm, bi, r;
      p5 = ($urandom % 3) == 0;
      p1 = p5 && (($urandom % 2) == 0);
      bm = ($urandom % 30) == 0;
      bi = ($urandom % 4) == 0;
      r  = ($urandom % 1500) == 0;
      step(r, p1, p5, bm, bi);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
